// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam logic [3:0]  SEL_IDLE   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // A digit above 0 is blank when it and every more significant nibble is zero
  // and no decimal point is requested on it.
  function automatic logic lzb_blank(logic [15:0] val, logic [3:0] dpm, digit_idx_t k);
    logic [15:0] upper;
    upper = val >> (NIBBLE_W * k);
    return (k != 2'd0) && (upper == 16'h0000) && !dpm[k];
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Value-load and digit-drive signals of display_scanner.
interface display_scanner_if;
  import display_pkg::*;

  logic [NUM_DIGITS*NIBBLE_W-1:0] value;
  logic [NUM_DIGITS-1:0]          dp_mask;
  logic                           load;
  logic [NIBBLE_W-1:0]            number;
  logic [NUM_DIGITS-1:0]          digit_sel;
  logic                           dp;
  logic                           blank;
  logic                           frame_done;

  modport master (
    output value, dp_mask, load,
    input  number, digit_sel, dp, blank, frame_done
  );

  modport slave (
    input  value, dp_mask, load,
    output number, digit_sel, dp, blank, frame_done
  );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running 0..CLK_DIV-1 divider; tick is high on the last count of each dwell.
module scan_prescaler #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] div_cnt_q;

  assign tick = (div_cnt_q == CntMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned double buffering.
// Define DISPLAY_SCANNER_LZB_EN to enable leading-zero blanking.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  display_scanner_if.slave  bus
);

  logic       tick;
  logic       boundary;
  digit_idx_t idx_q, idx_d;

  logic [15:0] pend_val_q, disp_val_q, disp_val_d;
  logic [3:0]  pend_dp_q, disp_dp_q, disp_dp_d;
  logic        pend_flag_q;

  logic [3:0] number_q, number_d;
  logic [3:0] sel_q, sel_d;
  logic       dp_q, dp_d;
  logic       blank_q, blank_d;
  logic       frame_done_q;

  scan_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    boundary   = tick && (idx_q == 2'd3);
    idx_d      = digit_idx_t'(idx_q + 2'd1);
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    // A load landing on the boundary itself bypasses the pending buffer.
    if (boundary) begin
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_mask;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end
    number_d = disp_val_d[NIBBLE_W*idx_d +: NIBBLE_W];
    sel_d    = ~(4'b0001 << idx_d);
    dp_d     = disp_dp_d[idx_d];
`ifdef DISPLAY_SCANNER_LZB_EN
    blank_d  = lzb_blank(disp_val_d, disp_dp_d, idx_d);
    if (blank_d) begin
      sel_d = SEL_IDLE;
    end
`else
    blank_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      number_q     <= 4'h0;
      sel_q        <= 4'b1110;
      dp_q         <= 1'b0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      if (boundary) begin
        pend_flag_q <= 1'b0;
      end else if (bus.load) begin
        pend_val_q  <= bus.value;
        pend_dp_q   <= bus.dp_mask;
        pend_flag_q <= 1'b1;
      end
      if (tick) begin
        idx_q    <= idx_d;
        number_q <= number_d;
        sel_q    <= sel_d;
        dp_q     <= dp_d;
        blank_q  <= blank_d;
      end
    end
  end

  assign bus.number     = number_q;
  assign bus.digit_sel  = sel_q;
  assign bus.dp         = dp_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed, table-driven bench for display_scanner with CLK_DIV = 4.
module tb_display_scanner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  display_scanner_if sif ();

  display_scanner #(
    .CLK_DIV(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpm;
    logic [15:0] exp_num;   // nibble k = number expected on digit k
    logic [3:0]  exp_dp;    // bit k = dp expected on digit k
    logic [3:0]  exp_blank; // bit k = blank expected on digit k
    logic [15:0] exp_sel;   // nibble k = digit_sel expected on digit k
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    @(negedge clk);
    sif.value   = v;
    sif.dp_mask = m;
    sif.load    = 1'b1;
    @(negedge clk);
    sif.load    = 1'b0;
  endtask

  // Leaves the bench on the first cycle of a frame (frame_done high).
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sif.frame_done) found = 1'b1;
      else @(negedge clk);
    end
    chk("frame_done_seen", 16'(found), 16'h1);
  endtask

  // Entered at frame offset 0, leaves at offset 13.
  task automatic check_frame(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) @(negedge clk);
      chk("number", 16'(sif.number), 16'(v.exp_num[4*k +: 4]));
      chk("digit_sel", 16'(sif.digit_sel), 16'(v.exp_sel[4*k +: 4]));
      chk("dp", 16'(sif.dp), 16'(v.exp_dp[k]));
      chk("blank", 16'(sif.blank), 16'(v.exp_blank[k]));
      if (k == 0) chk("frame_done_single", 16'(sif.frame_done), 16'h0);
    end
  endtask

  logic [3:0] sel_after_hold;

  initial begin
`ifdef DISPLAY_SCANNER_LZB_EN
    vecs[0] = '{16'h1234, 4'b0100, 16'h1234, 4'b0100, 4'b0000, 16'h7BDE};
    vecs[1] = '{16'h0070, 4'b0000, 16'h0070, 4'b0000, 4'b1100, 16'hFFDE};
    vecs[2] = '{16'h0000, 4'b1000, 16'h0000, 4'b1000, 4'b0110, 16'h7FFE};
    vecs[3] = '{16'hF00E, 4'b0001, 16'hF00E, 4'b0001, 4'b0000, 16'h7BDE};
    vecs[4] = '{16'h0A05, 4'b0010, 16'h0A05, 4'b0010, 4'b1000, 16'hFBDE};
    sel_after_hold = 4'b1111;
`else
    vecs[0] = '{16'h1234, 4'b0100, 16'h1234, 4'b0100, 4'b0000, 16'h7BDE};
    vecs[1] = '{16'h0070, 4'b0000, 16'h0070, 4'b0000, 4'b0000, 16'h7BDE};
    vecs[2] = '{16'h0000, 4'b1000, 16'h0000, 4'b1000, 4'b0000, 16'h7BDE};
    vecs[3] = '{16'hF00E, 4'b0001, 16'hF00E, 4'b0001, 4'b0000, 16'h7BDE};
    vecs[4] = '{16'h0A05, 4'b0010, 16'h0A05, 4'b0010, 4'b0000, 16'h7BDE};
    sel_after_hold = 4'b1101;
`endif
    sif.value   = '0;
    sif.dp_mask = '0;
    sif.load    = 1'b0;

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_digit_sel", 16'(sif.digit_sel), 16'h000E);
    chk("rst_number", 16'(sif.number), 16'h0);
    chk("rst_dp", 16'(sif.dp), 16'h0);
    chk("rst_blank", 16'(sif.blank), 16'h0);
    chk("rst_frame_done", 16'(sif.frame_done), 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Digit 0 held for exactly four cycles after release.
    for (int i = 0; i < 4; i++) begin
      chk("hold_digit0", 16'(sif.digit_sel), 16'h000E);
      @(negedge clk);
    end
    chk("after_hold", 16'(sif.digit_sel), 16'(sel_after_hold));

    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].val, vecs[i].dpm);
      wait_frame();
      check_frame(vecs[i]);
    end

    // Frame alignment: a load during digit 1 waits for the next frame.
    do_load(16'h1234, 4'b0000);
    wait_frame();
    repeat (5) @(negedge clk);
    do_load(16'hABCD, 4'b0000);
    repeat (2) @(negedge clk);
    chk("align_d2_old", 16'(sif.number), 16'h2);
    chk("align_no_pulse", 16'(sif.frame_done), 16'h0);
    repeat (4) @(negedge clk);
    chk("align_d3_old", 16'(sif.number), 16'h1);
    repeat (3) @(negedge clk);
    chk("align_period16", 16'(sif.frame_done), 16'h1);
    chk("align_d0_new", 16'(sif.number), 16'hD);
    chk("align_sel", 16'(sif.digit_sel), 16'h000E);

    // Last write wins within a frame.
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    repeat (2) @(negedge clk);
    chk("lww_still_old", 16'(sif.number), 16'hC);
    wait_frame();
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) @(negedge clk);
      chk("lww_number", 16'(sif.number), 16'h2);
    end
    repeat (3) @(negedge clk);
    chk("lww_next_frame", 16'(sif.frame_done), 16'h1);

    // Load in the boundary cycle shows on the very next frame.
    repeat (14) @(negedge clk);
    do_load(16'h5A5A, 4'b0000);
    chk("bnd_frame_done", 16'(sif.frame_done), 16'h1);
    chk("bnd_d0", 16'(sif.number), 16'hA);
    repeat (5) @(negedge clk);
    chk("bnd_d1", 16'(sif.number), 16'h5);

    // Reset mid-frame discards a pending load.
    do_load(16'h9999, 4'b1111);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sel", 16'(sif.digit_sel), 16'h000E);
    chk("mid_rst_number", 16'(sif.number), 16'h0);
    chk("mid_rst_dp", 16'(sif.dp), 16'h0);
    chk("mid_rst_frame_done", 16'(sif.frame_done), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_frame();
    chk("discard_d0", 16'(sif.number), 16'h0);
    chk("discard_dp0", 16'(sif.dp), 16'h0);
    repeat (5) @(negedge clk);
    chk("discard_d1", 16'(sif.number), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
